// File: rtl/pmem_burst_pkg.sv
// Shared types and geometry for the cache-line to burst-memory adaptor.
// Holds the FSM state encoding, line/beat widths and the beat-count width.
package pmem_burst_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Burst memory is addressed on 32-byte boundaries
    function automatic logic [31:0] align_line_addr(input logic [31:0] addr);
        return {addr[31:5], 5'b0_0000};
    endfunction

endpackage

// File: rtl/burst_beat_buffer.sv
// Line-wide data register with a per-beat write port and a beat-select read mux.
// Loaded whole for writes, filled one beat at a time for reads.
module burst_beat_buffer #(
    parameter int LINE_W = pmem_burst_pkg::LINE_W,
    parameter int BEAT_W = pmem_burst_pkg::BEAT_W,
    parameter int BEATS  = LINE_W / BEAT_W,
    parameter int SEL_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_load,
    input  logic [LINE_W-1:0] line_in,
    input  logic              beat_we,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [BEAT_W-1:0] beat_in,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [LINE_W-1:0] line_out,
    output logic [BEAT_W-1:0] beat_out
);
    import pmem_burst_pkg::*;

    logic [LINE_W-1:0] line_r;

    // Line storage: reset clears, whole-line load beats single-beat fill
    always_ff @(posedge clk) begin
        if (rst) begin
            line_r <= '0;
        end else if (line_load) begin
            line_r <= line_in;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if (beat_we && (wr_sel == SEL_W'(i))) begin
                    line_r[i*BEAT_W +: BEAT_W] <= beat_in;
                end
            end
        end
    end

    // Beat-select read mux; a select past the last beat reads as zero
    always_comb begin
        beat_out = '0;
        for (int i = 0; i < BEATS; i++) begin
            beat_out = (rd_sel == SEL_W'(i)) ? line_r[i*BEAT_W +: BEAT_W] : beat_out;
        end
    end

    assign line_out = line_r;

endmodule

// File: rtl/pmem_burst_adaptor.sv
// Splits cache-line reads/writes into BEATS-long bursts to beat-wide memory.
// The FSM and beat counter live here; line data lives in burst_beat_buffer.
module pmem_burst_adaptor #(
    parameter int LINE_W = pmem_burst_pkg::LINE_W,
    parameter int BEAT_W = pmem_burst_pkg::BEAT_W,
    parameter int BEATS  = LINE_W / BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       line_addr,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    input  logic              line_read,
    input  logic              line_write,
    output logic              line_resp,
    output logic [31:0]       burst_addr,
    input  logic [BEAT_W-1:0] burst_rdata,
    output logic [BEAT_W-1:0] burst_wdata,
    output logic              burst_read,
    output logic              burst_write,
    input  logic              burst_resp
);
    import pmem_burst_pkg::*;

    localparam int               SEL_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(BEATS - 1);

    state_t            state_r;
    logic [SEL_W-1:0]  cnt_r;
    logic [LINE_W-1:0] line_rdata_r;
    logic              line_resp_r;
    logic [31:0]       burst_addr_r;
    logic [BEAT_W-1:0] burst_wdata_r;
    logic              burst_read_r;
    logic              burst_write_r;

    logic [SEL_W-1:0]  next_sel_s;
    logic              last_beat_s;
    logic              rd_beat_s;
    logic              line_load_s;
    logic [LINE_W-1:0] buf_line_s;
    logic [BEAT_W-1:0] buf_beat_s;
    logic [LINE_W-1:0] rd_line_s;

    // Beat bookkeeping shared by the FSM and the line buffer
    always_comb begin
        next_sel_s  = cnt_r + SEL_W'(1);
        last_beat_s = (cnt_r == LAST_BEAT);
        rd_beat_s   = (state_r == RD_BURST) && burst_resp;
        line_load_s = (state_r == IDLE) && line_write;
    end

    // Completed read line: buffered beats with the arriving beat in its slot
    always_comb begin
        rd_line_s = buf_line_s;
        for (int i = 0; i < BEATS; i++) begin
            rd_line_s[i*BEAT_W +: BEAT_W] = (cnt_r == SEL_W'(i)) ? burst_rdata
                                                                  : buf_line_s[i*BEAT_W +: BEAT_W];
        end
    end

    burst_beat_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS),
        .SEL_W  (SEL_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .line_load (line_load_s),
        .line_in   (line_wdata),
        .beat_we   (rd_beat_s),
        .wr_sel    (cnt_r),
        .beat_in   (burst_rdata),
        .rd_sel    (next_sel_s),
        .line_out  (buf_line_s),
        .beat_out  (buf_beat_s)
    );

    // Control FSM with registered memory- and line-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            line_rdata_r  <= '0;
            line_resp_r   <= 1'b0;
            burst_addr_r  <= 32'h0000_0000;
            burst_wdata_r <= '0;
            burst_read_r  <= 1'b0;
            burst_write_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Write wins a tie; first write beat is presented immediately
                    if (line_write) begin
                        state_r       <= WR_BURST;
                        cnt_r         <= '0;
                        burst_addr_r  <= align_line_addr(line_addr);
                        burst_wdata_r <= line_wdata[BEAT_W-1:0];
                        burst_write_r <= 1'b1;
                    end else if (line_read) begin
                        state_r      <= RD_BURST;
                        cnt_r        <= '0;
                        burst_addr_r <= align_line_addr(line_addr);
                        burst_read_r <= 1'b1;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        if (last_beat_s) begin
                            state_r      <= DONE;
                            cnt_r        <= '0;
                            burst_read_r <= 1'b0;
                            line_resp_r  <= 1'b1;
                            line_rdata_r <= rd_line_s;
                        end else begin
                            cnt_r <= next_sel_s;
                        end
                    end
                end
                WR_BURST: begin
                    if (burst_resp) begin
                        if (last_beat_s) begin
                            state_r       <= DONE;
                            cnt_r         <= '0;
                            burst_write_r <= 1'b0;
                            line_resp_r   <= 1'b1;
                        end else begin
                            cnt_r         <= next_sel_s;
                            burst_wdata_r <= buf_beat_s;
                        end
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    line_resp_r <= 1'b0;
                end
                default: begin
                    state_r       <= IDLE;
                    cnt_r         <= '0;
                    line_resp_r   <= 1'b0;
                    burst_read_r  <= 1'b0;
                    burst_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign line_rdata  = line_rdata_r;
    assign line_resp   = line_resp_r;
    assign burst_addr  = burst_addr_r;
    assign burst_wdata = burst_wdata_r;
    assign burst_read  = burst_read_r;
    assign burst_write = burst_write_r;

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Scoreboard bench for pmem_burst_adaptor: a driver issues line requests, a
// memory responder supplies beats, and a negedge monitor checks the DUT.
module tb_pmem_burst_adaptor;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;

    typedef struct {
        bit                wr;
        logic [31:0]       addr;
        logic [LINE_W-1:0] data;
    } txn_t;

    typedef struct {
        int                cyc;
        logic [LINE_W-1:0] rdata;
    } done_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       line_addr;
    logic [LINE_W-1:0] line_wdata;
    logic [LINE_W-1:0] line_rdata;
    logic              line_read;
    logic              line_write;
    logic              line_resp;
    logic [31:0]       burst_addr;
    logic [BEAT_W-1:0] burst_rdata = '0;
    logic [BEAT_W-1:0] burst_wdata;
    logic              burst_read;
    logic              burst_write;
    logic              burst_resp = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    txn_t  txn_q[$];
    done_t done_q[$];
    bit    pat_q[$];

    bit                fixed_en = 1'b0;
    bit                gapped   = 1'b0;
    bit                noise_en = 1'b0;
    int                rcnt     = 0;
    logic [LINE_W-1:0] rline    = '0;
    logic [BEAT_W-1:0] fixed_beats [BEATS];

    pmem_burst_adaptor #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .line_addr   (line_addr),
        .line_wdata  (line_wdata),
        .line_rdata  (line_rdata),
        .line_read   (line_read),
        .line_write  (line_write),
        .line_resp   (line_resp),
        .burst_addr  (burst_addr),
        .burst_rdata (burst_rdata),
        .burst_wdata (burst_wdata),
        .burst_read  (burst_read),
        .burst_write (burst_write),
        .burst_resp  (burst_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [BEAT_W-1:0] rand_beat();
        return {$urandom, $urandom};
    endfunction

    task automatic check_zero_outputs(input string tag);
        check(line_rdata == '0, {tag, "_line_rdata"}, line_rdata, '0);
        check(line_resp == 1'b0, {tag, "_line_resp"}, line_resp, '0);
        check(burst_read == 1'b0, {tag, "_burst_read"}, burst_read, '0);
        check(burst_write == 1'b0, {tag, "_burst_write"}, burst_write, '0);
        check(burst_addr == 32'h0, {tag, "_burst_addr"}, burst_addr, '0);
        check(burst_wdata == '0, {tag, "_burst_wdata"}, burst_wdata, '0);
    endtask

    // Raise a line request, hold it until line_resp, then drop it
    task automatic run(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [LINE_W-1:0] d);
        txn_t t;
        bit   got;
        t.wr   = wr;
        t.addr = a;
        t.data = d;
        txn_q.push_back(t);
        line_addr  = a;
        line_wdata = d;
        line_read  = rd;
        line_write = wr;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (line_resp) begin
                got = 1'b1;
                break;
            end
        end
        check(got, "line_resp_timeout", got, 1'b1);
        line_read  = 1'b0;
        line_write = 1'b0;
        line_addr  = $urandom;
        line_wdata = rand_line();
    endtask

    // Memory model: answers active bursts, injects noise when idle
    initial begin : responder
        bit                r;
        logic [BEAT_W-1:0] beat;
        done_t             d;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                rcnt = 0;
                rline = '0;
                done_q.delete();
                burst_resp  = 1'($urandom_range(0, 1));
                burst_rdata = rand_beat();
            end else if (burst_read || burst_write) begin
                if (pat_q.size() > 0) r = pat_q.pop_front();
                else if (gapped)      r = 1'($urandom_range(0, 1));
                else                  r = 1'b1;
                beat = (burst_read && fixed_en) ? fixed_beats[rcnt] : rand_beat();
                burst_resp  = r;
                burst_rdata = beat;
                if (r) begin
                    if (burst_read) rline[rcnt*BEAT_W +: BEAT_W] = beat;
                    rcnt++;
                    if (rcnt == BEATS) begin
                        d.cyc   = cyc + 1;
                        d.rdata = rline;
                        done_q.push_back(d);
                        rcnt  = 0;
                        rline = '0;
                    end
                end
            end else begin
                burst_resp  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                burst_rdata = rand_beat();
            end
        end
    end

    // Monitor: checks burst traffic and pops the scoreboard on line_resp
    initial begin : monitor
        txn_t              t;
        done_t             d;
        int                bcnt;
        bit                prev_resp;
        logic [LINE_W-1:0] last_rdata;
        bcnt = 0;
        prev_resp = 1'b0;
        last_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt = 0;
                prev_resp = 1'b0;
                last_rdata = '0;
            end else begin
                if (burst_read || burst_write) begin
                    check(!(burst_read && burst_write), "rd_wr_exclusive",
                          {burst_read, burst_write}, 2'b00);
                    if (txn_q.size() == 0) begin
                        check(1'b0, "burst_without_request", {burst_read, burst_write}, 2'b00);
                    end else begin
                        t = txn_q[0];
                        check(burst_addr == (t.addr & 32'hFFFF_FFE0), "burst_addr",
                              burst_addr, t.addr & 32'hFFFF_FFE0);
                        check(burst_write == t.wr, "burst_kind", burst_write, t.wr);
                        check(bcnt < BEATS, "beat_overrun", bcnt, BEATS);
                        if (burst_resp && burst_write && bcnt < BEATS)
                            check(burst_wdata == t.data[bcnt*BEAT_W +: BEAT_W], "burst_wdata",
                                  burst_wdata, t.data[bcnt*BEAT_W +: BEAT_W]);
                    end
                    if (burst_resp) bcnt++;
                end
                if (line_resp) begin
                    check(!prev_resp, "line_resp_width", 2'b11, 2'b01);
                    if (txn_q.size() == 0 || done_q.size() == 0) begin
                        check(1'b0, "unexpected_line_resp", line_resp, 1'b0);
                    end else begin
                        t = txn_q.pop_front();
                        d = done_q.pop_front();
                        check(cyc == d.cyc, "line_resp_latency", cyc, d.cyc);
                        check(bcnt == BEATS, "beats_per_line", bcnt, BEATS);
                        if (t.wr) begin
                            check(line_rdata == last_rdata, "line_rdata_after_write",
                                  line_rdata, last_rdata);
                        end else begin
                            check(line_rdata == d.rdata, "line_rdata", line_rdata, d.rdata);
                            last_rdata = d.rdata;
                        end
                    end
                    bcnt = 0;
                end else begin
                    check(line_rdata == last_rdata, "line_rdata_stable", line_rdata, last_rdata);
                end
                prev_resp = line_resp;
            end
        end
    end

    initial begin : driver
        logic [LINE_W-1:0] exp_line;
        logic [LINE_W-1:0] wline;
        bit                seen;
        rst        = 1'b1;
        line_read  = 1'b0;
        line_write = 1'b0;
        line_addr  = 32'h0;
        line_wdata = '0;
        fixed_beats[0] = 64'h1111_1111_1111_1111;
        fixed_beats[1] = 64'h2222_2222_2222_2222;
        fixed_beats[2] = 64'h3333_3333_3333_3333;
        fixed_beats[3] = 64'h4444_4444_4444_4444;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #2; end

        // Consecutive fixed-pattern read from an unaligned address
        fixed_en = 1'b1;
        run(1'b1, 1'b0, 32'h0000_1234, '0);
        fixed_en = 1'b0;
        exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        check(line_rdata == exp_line, "directed_read_line", line_rdata, exp_line);

        // Gapped read
        pat_q.push_back(1'b1); pat_q.push_back(1'b0); pat_q.push_back(1'b0);
        pat_q.push_back(1'b1); pat_q.push_back(1'b1); pat_q.push_back(1'b0);
        pat_q.push_back(1'b1);
        run(1'b1, 1'b0, 32'h0000_ABCD, '0);

        // Simultaneous read and write: write must win
        run(1'b1, 1'b1, 32'h8000_0040, rand_line());

        // Directed write, then back-to-back read
        wline = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                 64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
        run(1'b0, 1'b1, 32'h0000_2000, wline);
        run(1'b1, 1'b0, 32'h0000_2000, '0);

        // Reset in the middle of a read
        begin
            txn_t t;
            t.wr = 1'b0; t.addr = 32'h0000_3000; t.data = '0;
            txn_q.push_back(t);
            line_addr = 32'h0000_3000;
            line_read = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(posedge clk);
                #2;
                if (rcnt >= 2) begin
                    seen = 1'b1;
                    break;
                end
            end
            check(seen, "mid_burst_wait", seen, 1'b1);
            rst = 1'b1;
            line_read = 1'b0;
            txn_q.delete();
            @(posedge clk);
            @(negedge clk);
            check_zero_outputs("mid_reset");
            @(posedge clk);
            #2;
            rst = 1'b0;
            repeat (5) begin @(posedge clk); #2; end
        end
        run(1'b1, 1'b0, 32'h0000_3000, '0);

        // Randomized traffic with gaps and idle-time beat noise
        gapped   = 1'b1;
        noise_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            bit wr;
            wr = 1'($urandom_range(0, 1));
            run(wr ? 1'($urandom_range(0, 1)) : 1'b1, wr, $urandom, rand_line());
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end

        repeat (10) @(posedge clk);
        #2;
        check(txn_q.size() == 0 && done_q.size() == 0, "scoreboard_drained",
              txn_q.size() + done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
